// File: rtl/hilo_md_sequencer_if.sv
// hilo_md_sequencer_if: E-stage request bus and HI/LO result bus of the multiply/divide unit
//   i_start  request qualifier          i_op    0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO
//   i_rs     operand A / MT source      i_rt    operand B (divisor)
//   i_cancel exception flush            o_busy  op in flight (to stall unit)
//   o_done   one-cycle result pulse     o_hi/o_lo  HI/LO registers
interface hilo_md_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             i_start;
   logic [3:0]       i_op;
   logic [WIDTH-1:0] i_rs;
   logic [WIDTH-1:0] i_rt;
   logic             i_cancel;
   logic             o_busy;
   logic             o_done;
   logic [WIDTH-1:0] o_hi;
   logic [WIDTH-1:0] o_lo;
   modport master (
      output i_start, i_op, i_rs, i_rt, i_cancel,
      input  o_busy, o_done, o_hi, o_lo
   );
   modport slave (
      input  i_start, i_op, i_rs, i_rt, i_cancel,
      output o_busy, o_done, o_hi, o_lo
   );
endinterface

// File: rtl/hilo_md_sequencer.sv
// hilo_md_sequencer: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-low reset
//   md       slave side of hilo_md_sequencer_if (request in, busy/done/hi/lo out)
module hilo_md_sequencer #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input logic               i_clk,
   input logic               i_reset,
   hilo_md_sequencer_if.slave md
);
   localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t             r_state, w_next;
   logic [CW-1:0]      r_count;
   logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
   logic               r_div, r_signed, r_busy, r_done;
   logic               w_accept, w_is_mul, w_is_div, w_commit, w_busy_d;
   logic               w_neg_a, w_neg_b;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_uq, w_ur, w_quo, w_rem;
   logic [2*WIDTH-1:0] w_prod;
   assign w_is_mul = md.i_op == 4'd1 || md.i_op == 4'd2;
   assign w_is_div = md.i_op == 4'd3 || md.i_op == 4'd4;
   // Result is formed from the latched operands; only the commit cycle uses it.
   assign w_neg_a = r_signed & r_a[WIDTH-1];
   assign w_neg_b = r_signed & r_b[WIDTH-1];
   assign w_prod  = {{WIDTH{w_neg_a}}, r_a} * {{WIDTH{w_neg_b}}, r_b};
   // Signed divide via magnitudes: avoids the MIN/-1 overflow case, which wraps naturally.
   assign w_abs_a = w_neg_a ? -r_a : r_a;
   assign w_abs_b = w_neg_b ? -r_b : r_b;
   assign w_uq    = (w_abs_b == '0) ? '0 : w_abs_a / w_abs_b;
   assign w_ur    = (w_abs_b == '0) ? '0 : w_abs_a % w_abs_b;
   assign w_quo   = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
   assign w_rem   = w_neg_a ? -w_ur : w_ur;
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= IDLE;
      else          r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      if (r_state == IDLE) w_next = (w_accept && (w_is_mul || w_is_div)) ? RUN : IDLE;
      else                 w_next = (md.i_cancel || r_count == '0) ? IDLE : RUN;
   end
   always_comb begin
      w_accept = md.i_start && !md.i_cancel && r_state == IDLE;
      w_commit = r_state == RUN && !md.i_cancel && r_count == '0;
      w_busy_d = w_next == RUN;
   end
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_count  <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_div    <= 1'b0;
         r_signed <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_busy <= w_busy_d;
         r_done <= w_commit;
         if (w_accept && (w_is_mul || w_is_div)) begin
            r_a      <= md.i_rs;
            r_b      <= md.i_rt;
            r_div    <= w_is_div;
            r_signed <= md.i_op == 4'd1 || md.i_op == 4'd3;
            r_count  <= w_is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
         end else if (r_state == RUN && r_count != '0) begin
            r_count <= r_count - 1'b1;
         end
         if (w_accept && md.i_op == 4'd5) r_hi <= md.i_rs;
         if (w_accept && md.i_op == 4'd6) r_lo <= md.i_rs;
         // A zero divisor still runs the full latency and pulses done, but leaves HI/LO alone.
         if (w_commit && !(r_div && r_b == '0)) begin
            r_hi <= r_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
            r_lo <= r_div ? w_quo : w_prod[WIDTH-1:0];
         end
      end
   end
   assign md.o_busy = r_busy;
   assign md.o_done = r_done;
   assign md.o_hi   = r_hi;
   assign md.o_lo   = r_lo;
   // The stall unit must hold the request while busy; a start here is silently dropped.
   a_no_start_while_run: assert property (@(posedge i_clk) disable iff (!i_reset)
      !(r_state == RUN && md.i_start && !md.i_cancel));
endmodule

// File: tb/tb_hilo_md_sequencer.sv
// tb_hilo_md_sequencer: table-driven and directed checks of the HI/LO multiply/divide sequencer
module tb_hilo_md_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   hilo_md_sequencer_if #(.WIDTH(32)) md ();
   hilo_md_sequencer #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .md      (md)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      int          n;
      logic        dn;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;
   vec_t v[15];
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   initial begin
      int n;
      logic [31:0] hi_s, lo_s;
      md.i_start  = 1'b0;
      md.i_op     = 4'd0;
      md.i_rs     = '0;
      md.i_rt     = '0;
      md.i_cancel = 1'b0;
      v[0]  = '{4'd1, 32'hFFFFFFFE, 32'h00000003, 5,  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
      v[1]  = '{4'd2, 32'hFFFFFFFF, 32'h00000002, 5,  1'b1, 32'h00000001, 32'hFFFFFFFE};
      v[2]  = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
      v[3]  = '{4'd4, 32'h00000007, 32'h00000000, 10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
      v[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1'b1, 32'h00000000, 32'h80000000};
      v[5]  = '{4'd4, 32'h00000064, 32'h00000007, 10, 1'b1, 32'h00000002, 32'h0000000E};
      v[6]  = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 10, 1'b1, 32'h00000001, 32'hFFFFFFFD};
      v[7]  = '{4'd1, 32'h00010000, 32'h00010000, 5,  1'b1, 32'h00000001, 32'h00000000};
      v[8]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  1'b1, 32'h00000000, 32'h00000001};
      v[9]  = '{4'd5, 32'h12345678, 32'h0,        0,  1'b0, 32'h12345678, 32'h00000001};
      v[10] = '{4'd6, 32'h9ABCDEF0, 32'h0,        0,  1'b0, 32'h12345678, 32'h9ABCDEF0};
      v[11] = '{4'd3, 32'h00000000, 32'h00000000, 10, 1'b1, 32'h12345678, 32'h9ABCDEF0};
      v[12] = '{4'd4, 32'hFFFFFFFF, 32'h00000001, 10, 1'b1, 32'h00000000, 32'hFFFFFFFF};
      v[13] = '{4'd2, 32'h80000000, 32'h80000000, 5,  1'b1, 32'h40000000, 32'h00000000};
      v[14] = '{4'd7, 32'h55555555, 32'h11111111, 0,  1'b0, 32'h40000000, 32'h00000000};
      #1;
      chk("reset_busy", {31'd0, md.o_busy}, 32'd0);
      chk("reset_done", {31'd0, md.o_done}, 32'd0);
      chk("reset_hi", md.o_hi, 32'd0);
      chk("reset_lo", md.o_lo, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 15; i++) begin
         md.i_start = 1'b1;
         md.i_op    = v[i].op;
         md.i_rs    = v[i].rs;
         md.i_rt    = v[i].rt;
         step();
         md.i_start = 1'b0;
         md.i_op    = 4'd0;
         n = 0;
         while (md.o_busy && n < 40) begin
            n++;
            step();
         end
         chk($sformatf("v%0d_busy_cycles", i), n, v[i].n);
         chk($sformatf("v%0d_done", i), {31'd0, md.o_done}, {31'd0, v[i].dn});
         chk($sformatf("v%0d_hi", i), md.o_hi, v[i].hi);
         chk($sformatf("v%0d_lo", i), md.o_lo, v[i].lo);
         step();
         chk($sformatf("v%0d_done_clear", i), {31'd0, md.o_done}, 32'd0);
      end
      // MTHI then MTLO back-to-back
      md.i_start = 1'b1;
      md.i_op    = 4'd5;
      md.i_rs    = 32'hCAFEBABE;
      step();
      chk("mthi_hi", md.o_hi, 32'hCAFEBABE);
      chk("mthi_busy", {31'd0, md.o_busy}, 32'd0);
      md.i_op = 4'd6;
      md.i_rs = 32'h0BADF00D;
      step();
      chk("mtlo_lo", md.o_lo, 32'h0BADF00D);
      chk("mtlo_hi_kept", md.o_hi, 32'hCAFEBABE);
      chk("mtlo_busy", {31'd0, md.o_busy}, 32'd0);
      md.i_start = 1'b0;
      md.i_op    = 4'd0;
      // DIV cancelled on its third busy cycle
      md.i_start = 1'b1;
      md.i_op    = 4'd3;
      md.i_rs    = 32'd100;
      md.i_rt    = 32'd3;
      step();
      md.i_start = 1'b0;
      md.i_op    = 4'd0;
      chk("cancel_busy1", {31'd0, md.o_busy}, 32'd1);
      step();
      step();
      chk("cancel_busy3", {31'd0, md.o_busy}, 32'd1);
      md.i_cancel = 1'b1;
      step();
      md.i_cancel = 1'b0;
      chk("cancel_busy_drop", {31'd0, md.o_busy}, 32'd0);
      n = 0;
      for (int k = 0; k < 12; k++) begin
         if (md.o_done || md.o_busy) n++;
         step();
      end
      chk("cancel_no_done", n, 0);
      chk("cancel_hi", md.o_hi, 32'hCAFEBABE);
      chk("cancel_lo", md.o_lo, 32'h0BADF00D);
      // start together with cancel is dropped, MT included
      md.i_start  = 1'b1;
      md.i_cancel = 1'b1;
      md.i_op     = 4'd1;
      md.i_rs     = 32'd9;
      md.i_rt     = 32'd9;
      step();
      chk("startcancel_busy", {31'd0, md.o_busy}, 32'd0);
      md.i_op = 4'd5;
      step();
      chk("startcancel_mthi", md.o_hi, 32'hCAFEBABE);
      md.i_op = 4'd6;
      step();
      chk("startcancel_mtlo", md.o_lo, 32'h0BADF00D);
      md.i_start  = 1'b0;
      md.i_cancel = 1'b0;
      md.i_op     = 4'd0;
      step();
      chk("startcancel_done", {31'd0, md.o_done}, 32'd0);
      // asynchronous reset in the middle of a DIV
      md.i_start = 1'b1;
      md.i_op    = 4'd4;
      md.i_rs    = 32'd50;
      md.i_rt    = 32'd5;
      step();
      md.i_start = 1'b0;
      md.i_op    = 4'd0;
      step();
      step();
      chk("rst_pre_busy", {31'd0, md.o_busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_busy", {31'd0, md.o_busy}, 32'd0);
      chk("rst_done", {31'd0, md.o_done}, 32'd0);
      chk("rst_hi", md.o_hi, 32'd0);
      chk("rst_lo", md.o_lo, 32'd0);
      step();
      rst_n = 1'b1;
      n = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (md.o_done || md.o_busy) n++;
      end
      chk("rst_idle_after", n, 0);
      chk("rst_hi_after", md.o_hi, 32'd0);
      // unit still works after reset
      md.i_start = 1'b1;
      md.i_op    = 4'd2;
      md.i_rs    = 32'd6;
      md.i_rt    = 32'd7;
      step();
      md.i_start = 1'b0;
      md.i_op    = 4'd0;
      n = 0;
      while (md.o_busy && n < 40) begin
         n++;
         step();
      end
      chk("post_rst_cycles", n, 5);
      chk("post_rst_lo", md.o_lo, 32'd42);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
